// File: rtl/colocar_barcos.sv
// colocar_barcos -- ship placement stage of the battleship game.
//
// The player steers a cursor over a FILAS x COLS board and drops ships one
// at a time; ship k (1-based) is k cells long and grows right (horizontal)
// or down (vertical) from the cursor. A placement is rejected if any cell
// falls off the board or lands on an occupied cell.
//
// Optional feature macro: COLOCAR_ROTACION_EN
//   defined   -> btnRotar toggles orientacion, vertical ships allowed
//   undefined -> btnRotar ignored, orientacion held at 0 (all horizontal)
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   cantidadBarcosSeleccionada ship count from the selection stage
//   seleccionListo             count valid (sampled only while waiting)
//   btnArriba/Abajo/Izq/Der    cursor moves (debounced levels)
//   btnRotar                   orientation toggle (level)
//   btnColocar                 place current ship (level)
//   tableroJugador             occupancy map, bit = fila*COLS+col
//   cursorFila, cursorCol      cursor position
//   orientacion                0 = horizontal, 1 = vertical
//   barcosColocados            ships placed so far
//   errorColocacion            one-cycle pulse on a rejected placement
//   colocacionLista            all ships placed (held until reset)
module colocar_barcos #(
    parameter int FILAS      = 5,
    parameter int COLS       = 5,
    parameter int MAX_BARCOS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             cantidadBarcosSeleccionada,
    input  logic                   seleccionListo,
    input  logic                   btnArriba,
    input  logic                   btnAbajo,
    input  logic                   btnIzq,
    input  logic                   btnDer,
    input  logic                   btnRotar,
    input  logic                   btnColocar,
    output logic [FILAS*COLS-1:0]  tableroJugador,
    output logic [2:0]             cursorFila,
    output logic [2:0]             cursorCol,
    output logic                   orientacion,
    output logic [2:0]             barcosColocados,
    output logic                   errorColocacion,
    output logic                   colocacionLista
);

    localparam int NCELDAS = FILAS * COLS;

    typedef enum logic [1:0] {ESPERA, COLOCANDO, LISTO} estado_t;

    estado_t              estado_q, estado_d;
    logic [NCELDAS-1:0]   tablero_q, tablero_d;
    logic [2:0]           fila_q, fila_d;
    logic [2:0]           col_q, col_d;
    logic                 orient_q, orient_d;
    logic [2:0]           barcos_q, barcos_d;
    logic [2:0]           cantidad_q, cantidad_d;
    logic                 error_q, error_d;
    logic                 lista_q, lista_d;
    logic [5:0]           btn_prev_q, btn_prev_d;

    // Button vector, highest priority in the MSB:
    // colocar, rotar, arriba, abajo, izq, der.
    logic [5:0]           btn_now;
    logic [5:0]           flanco;

`ifdef COLOCAR_ROTACION_EN
    assign btn_now = {btnColocar, btnRotar, btnArriba, btnAbajo, btnIzq, btnDer};
`else
    // Rotation disabled: the button never produces an action, so it cannot
    // shadow the lower-priority move buttons either.
    logic unused_rotar;
    assign unused_rotar = btnRotar;
    assign btn_now = {btnColocar, 1'b0, btnArriba, btnAbajo, btnIzq, btnDer};
`endif

    assign flanco = btn_now & ~btn_prev_q;

    // Footprint of the current ship and whether it fits on the board.
    logic [2:0]           largo;
    logic [NCELDAS-1:0]   huella;
    logic                 dentro;
    logic [3:0]           fila_k;
    logic [3:0]           col_k;

    always_comb begin
        largo  = barcos_q + 3'd1;
        huella = '0;
        dentro = 1'b1;
        fila_k = '0;
        col_k  = '0;
        for (int k = 0; k < MAX_BARCOS; k++) begin
            if (k < int'(largo)) begin
                fila_k = {1'b0, fila_q} + (orient_q ? 4'(k) : 4'd0);
                col_k  = {1'b0, col_q}  + (orient_q ? 4'd0 : 4'(k));
                if (fila_k >= 4'(FILAS) || col_k >= 4'(COLS))
                    dentro = 1'b0;
                else
                    huella = huella | ({{(NCELDAS-1){1'b0}}, 1'b1}
                                       << (int'(fila_k) * COLS + int'(col_k)));
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        tablero_d  = tablero_q;
        fila_d     = fila_q;
        col_d      = col_q;
        orient_d   = orient_q;
        barcos_d   = barcos_q;
        cantidad_d = cantidad_q;
        error_d    = 1'b0;
        lista_d    = lista_q;
        btn_prev_d = btn_now;

        case (estado_q)
            ESPERA: begin
                if (seleccionListo) begin
                    if (cantidadBarcosSeleccionada == 3'd0)
                        cantidad_d = 3'd1;
                    else if (cantidadBarcosSeleccionada > 3'(MAX_BARCOS))
                        cantidad_d = 3'(MAX_BARCOS);
                    else
                        cantidad_d = cantidadBarcosSeleccionada;
                    estado_d  = COLOCANDO;
                    tablero_d = '0;
                    fila_d    = '0;
                    col_d     = '0;
                    orient_d  = 1'b0;
                    barcos_d  = '0;
                end
            end
            COLOCANDO: begin
                // Single action per cycle; lower-priority edges are dropped.
                if (flanco[5]) begin
                    if (dentro && ((huella & tablero_q) == '0)) begin
                        tablero_d = tablero_q | huella;
                        barcos_d  = largo;
                        if (largo == cantidad_q) begin
                            estado_d = LISTO;
                            lista_d  = 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (flanco[4]) begin
                    orient_d = ~orient_q;
                end else if (flanco[3]) begin
                    if (fila_q != 3'd0) fila_d = fila_q - 3'd1;
                end else if (flanco[2]) begin
                    if (fila_q < 3'(FILAS - 1)) fila_d = fila_q + 3'd1;
                end else if (flanco[1]) begin
                    if (col_q != 3'd0) col_d = col_q - 3'd1;
                end else if (flanco[0]) begin
                    if (col_q < 3'(COLS - 1)) col_d = col_q + 3'd1;
                end
            end
            LISTO: begin
                // Frozen until reset.
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q   <= ESPERA;
            tablero_q  <= '0;
            fila_q     <= '0;
            col_q      <= '0;
            orient_q   <= 1'b0;
            barcos_q   <= '0;
            cantidad_q <= '0;
            error_q    <= 1'b0;
            lista_q    <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            estado_q   <= estado_d;
            tablero_q  <= tablero_d;
            fila_q     <= fila_d;
            col_q      <= col_d;
            orient_q   <= orient_d;
            barcos_q   <= barcos_d;
            cantidad_q <= cantidad_d;
            error_q    <= error_d;
            lista_q    <= lista_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign tableroJugador  = tablero_q;
    assign cursorFila      = fila_q;
    assign cursorCol       = col_q;
    assign orientacion     = orient_q;
    assign barcosColocados = barcos_q;
    assign errorColocacion = error_q;
    assign colocacionLista = lista_q;

endmodule

// File: tb/tb_colocar_barcos.sv
// Self-checking bench for colocar_barcos: a board-level reference model is
// stepped alongside the DUT and every output is compared each cycle, plus
// directed scenarios with hand-computed expectations.
module tb_colocar_barcos;

    localparam int F = 5;
    localparam int C = 5;
    localparam int N = F * C;

`ifdef COLOCAR_ROTACION_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    // Button bit positions in btn.
    localparam logic [5:0] B_COL = 6'b100000;
    localparam logic [5:0] B_ROT = 6'b010000;
    localparam logic [5:0] B_ARR = 6'b001000;
    localparam logic [5:0] B_ABA = 6'b000100;
    localparam logic [5:0] B_IZQ = 6'b000010;
    localparam logic [5:0] B_DER = 6'b000001;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   cant;
    logic         sel;
    logic [5:0]   btn;
    logic [N-1:0] tablero;
    logic [2:0]   cfila, ccol, barcos;
    logic         orient, err, lista;

    always #5 clk = ~clk;

    colocar_barcos dut (
        .clk                        (clk),
        .reset                      (rst),
        .cantidadBarcosSeleccionada (cant),
        .seleccionListo             (sel),
        .btnArriba                  (btn[3]),
        .btnAbajo                   (btn[2]),
        .btnIzq                     (btn[1]),
        .btnDer                     (btn[0]),
        .btnRotar                   (btn[4]),
        .btnColocar                 (btn[5]),
        .tableroJugador             (tablero),
        .cursorFila                 (cfila),
        .cursorCol                  (ccol),
        .orientacion                (orient),
        .barcosColocados            (barcos),
        .errorColocacion            (err),
        .colocacionLista            (lista)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 waiting, 1 placing, 2 done.
    int           m_est;
    bit           m_map [N];
    int           m_f, m_c, m_placed, m_cnt;
    bit           m_o, m_err, m_lista;
    logic [5:0]   m_prev;
    logic         err_seen;

    function automatic logic [N-1:0] map_bits();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_map[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic try_place();
        int  len = m_placed + 1;
        bit  ok  = 1'b1;
        int  r, cc;
        for (int k = 0; k < len; k++) begin
            r  = m_f + (m_o ? k : 0);
            cc = m_c + (m_o ? 0 : k);
            if (r >= F || cc >= C) ok = 1'b0;
            else if (m_map[r * C + cc]) ok = 1'b0;
        end
        if (ok) begin
            for (int k = 0; k < len; k++)
                m_map[(m_f + (m_o ? k : 0)) * C + (m_c + (m_o ? 0 : k))] = 1'b1;
            m_placed++;
            if (m_placed == m_cnt) begin
                m_est   = 2;
                m_lista = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_step();
        logic [5:0] e;
        if (!rst) begin
            m_est = 0; m_f = 0; m_c = 0; m_o = 0; m_placed = 0; m_cnt = 0;
            m_err = 0; m_lista = 0; m_prev = '0;
            foreach (m_map[i]) m_map[i] = 1'b0;
            return;
        end
        e      = btn & ~m_prev;
        m_prev = btn;
        m_err  = 1'b0;
        if (m_est == 0) begin
            if (sel) begin
                m_cnt = (cant == 0) ? 1 : ((cant > 5) ? 5 : int'(cant));
                m_est = 1; m_f = 0; m_c = 0; m_o = 0; m_placed = 0;
                foreach (m_map[i]) m_map[i] = 1'b0;
            end
        end else if (m_est == 1) begin
            if (e[5])              try_place();
            else if (e[4] && ROT)  m_o = ~m_o;
            else if (e[3])         m_f = (m_f > 0) ? m_f - 1 : 0;
            else if (e[2])         m_f = (m_f < F - 1) ? m_f + 1 : F - 1;
            else if (e[1])         m_c = (m_c > 0) ? m_c - 1 : 0;
            else if (e[0])         m_c = (m_c < C - 1) ? m_c + 1 : C - 1;
        end
    endtask

    // One clock: model advances on the same edge as the DUT, then all
    // outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("tablero", 32'(tablero), 32'(map_bits()));
        check("fila",    32'(cfila),   32'(m_f));
        check("col",     32'(ccol),    32'(m_c));
        check("orient",  32'(orient),  32'(m_o));
        check("barcos",  32'(barcos),  32'(m_placed));
        check("error",   32'(err),     32'(m_err));
        check("lista",   32'(lista),   32'(m_lista));
    endtask

    task automatic do_reset();
        rst = 1'b0; btn = '0; sel = 1'b0; cant = '0;
        repeat (3) cycle();
        rst = 1'b1;
    endtask

    task automatic start(input logic [2:0] n);
        cant = n; sel = 1'b1;
        cycle();
        sel = 1'b0;
        cycle();
    endtask

    task automatic press(input logic [5:0] m);
        btn = m;
        cycle();
        err_seen = err;
        btn = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b0; btn = '0; sel = 1'b0; cant = '0;

        // Reset values.
        do_reset();
        check("rst_tablero", 32'(tablero), 32'd0);
        check("rst_cursor",  32'({cfila, ccol}), 32'd0);
        check("rst_flags",   32'({orient, barcos, err, lista}), 32'd0);

        // Three ships.
        start(3'd3);
        press(B_COL);
        press(B_ABA);
        press(B_COL);
        press(B_ROT);
        press(B_ABA);
        repeat (4) press(B_DER);
        check("tres_cursor", 32'({cfila, ccol}), 32'({3'd2, 3'd4}));
        press(B_COL);
        if (ROT) begin
            check("tres_mapa", 32'(tablero), 32'h0108_4061);
        end else begin
            check("tres_err_h", 32'(err_seen), 32'd1);
            press(B_IZQ);
            press(B_IZQ);
            press(B_COL);
            check("tres_mapa", 32'(tablero), 32'h0000_7061);
        end
        check("tres_barcos", 32'(barcos), 32'd3);
        check("tres_lista",  32'(lista),  32'd1);
        press(B_ABA);
        check("tres_frozen", 32'({cfila, ccol}), 32'({3'd2, ROT ? 3'd4 : 3'd2}));

        // Out of bounds.
        do_reset();
        start(3'd2);
        press(B_COL);
        repeat (4) press(B_DER);
        press(B_COL);
        check("oob_err",    32'(err_seen), 32'd1);
        check("oob_barcos", 32'(barcos),   32'd1);
        check("oob_mapa",   32'(tablero),  32'd1);

        // Overlap and priority.
        do_reset();
        start(3'd3);
        press(B_DER);
        press(B_COL);
        press(B_IZQ);
        press(B_COL);
        check("ovl_err",  32'(err_seen), 32'd1);
        check("ovl_mapa", 32'(tablero),  32'd2);
        press(B_COL | B_DER);
        check("pri_err", 32'(err_seen), 32'd1);
        check("pri_col", 32'(ccol),     32'd0);

        // Clamp of zero.
        do_reset();
        start(3'd0);
        press(B_COL);
        check("cero_lista", 32'(lista), 32'd1);

        // Clamp of seven, saturation and held button.
        do_reset();
        start(3'd7);
        repeat (6) press(B_DER);
        check("sat_col", 32'(ccol), 32'd4);
        repeat (4) press(B_IZQ);
        btn = B_ABA;
        repeat (5) cycle();
        btn = '0;
        cycle();
        check("held_fila", 32'(cfila), 32'd1);
        for (int s = 0; s < 4; s++) begin
            press(B_COL);
            press(B_ABA);
        end
        check("siete_no_lista", 32'(lista), 32'd0);
        repeat (4) press(B_ARR);
        press(B_COL);
        check("siete_barcos", 32'(barcos), 32'd5);
        check("siete_lista",  32'(lista),  32'd1);

        // Reset mid-operation.
        do_reset();
        start(3'd4);
        press(B_COL);
        press(B_ABA);
        press(B_COL);
        do_reset();
        check("mid_mapa",   32'(tablero), 32'd0);
        check("mid_barcos", 32'(barcos),  32'd0);
        start(3'd1);
        press(B_COL);
        check("mid_lista", 32'(lista),   32'd1);
        check("mid_mapa1", 32'(tablero), 32'd1);

        // Randomized rounds against the model.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                cant = 3'($urandom_range(0, 7));
                sel  = ($urandom_range(0, 7) == 0);
                for (int b = 0; b < 6; b++)
                    btn[b] = ($urandom_range(0, 3) == 0);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
